// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcodes, and the decoded control bundle.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_NONE  = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_SLL   = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_XOR   = 4'd8,
    ALU_OR    = 4'd9,
    ALU_AND   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_AUIPC = 4'd12
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e         select_alu;
    logic            src1_sel;
    logic            src2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            branch_on_zero;
    logic            illegal;
  } dec_bundle_t;

  // alt selects SUB (funct3=000) or SRA (funct3=101); callers clear it where it is meaningless.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// Combinational RV32I instruction-to-bundle decode.
// ALU_DEC_ILLEGAL_EN: when defined, unrecognised encodings raise the illegal flag.
module alu_dec_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_bundle_t     bundle
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            wr_rd;
  logic            bad;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign wr_rd  = (instr[11:7] != 5'd0);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {12'd0, instr[31:12]};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    bundle     = '0;
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    bundle.rd  = instr[11:7];
    bad        = 1'b0;
    case (opcode)
      OPC_OP: begin
        bundle.select_alu = alu_from_funct(funct3, instr[30]);
        bundle.reg_write  = wr_rd;
        bad = (funct7 != 7'b0000000) &&
              !((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        bundle.select_alu = alu_from_funct(funct3, (funct3 == 3'b101) && instr[30]);
        bundle.src2_sel   = 1'b1;
        bundle.reg_write  = wr_rd;
        bundle.imm        = imm_i;
        // Shifts carry the shift amount, not a sign-extended immediate.
        if (funct3 == 3'b001) begin
          bundle.imm = {27'd0, instr[24:20]};
          bad        = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          bundle.imm = {27'd0, instr[24:20]};
          bad        = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OPC_LUI: begin
        bundle.select_alu = ALU_LUI;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_u;
        bundle.reg_write  = wr_rd;
      end
      OPC_AUIPC: begin
        bundle.select_alu = ALU_AUIPC;
        bundle.src1_sel   = 1'b1;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_u;
        bundle.reg_write  = wr_rd;
      end
      OPC_LOAD: begin
        bundle.select_alu = ALU_ADD;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_i;
        bundle.reg_write  = wr_rd;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        bundle.select_alu = ALU_ADD;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_s;
        bad = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
      end
      OPC_JALR: begin
        bundle.select_alu = ALU_ADD;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_i;
        bundle.reg_write  = wr_rd;
        bad = (funct3 != 3'b000);
      end
      OPC_JAL: begin
        bundle.select_alu = ALU_ADD;
        bundle.src1_sel   = 1'b1;
        bundle.src2_sel   = 1'b1;
        bundle.imm        = imm_j;
        bundle.reg_write  = wr_rd;
      end
      OPC_BRANCH: begin
        bundle.is_branch = 1'b1;
        bundle.imm       = imm_b;
        case (funct3)
          3'b000: begin bundle.select_alu = ALU_SUB;  bundle.branch_on_zero = 1'b1; end
          3'b001: begin bundle.select_alu = ALU_SUB;  bundle.branch_on_zero = 1'b0; end
          3'b100: begin bundle.select_alu = ALU_SLT;  bundle.branch_on_zero = 1'b0; end
          3'b101: begin bundle.select_alu = ALU_SLT;  bundle.branch_on_zero = 1'b1; end
          3'b110: begin bundle.select_alu = ALU_SLTU; bundle.branch_on_zero = 1'b0; end
          3'b111: begin bundle.select_alu = ALU_SLTU; bundle.branch_on_zero = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    // Unrecognised encodings collapse to a harmless rs1+imm add that writes nothing.
    if (bad) begin
      bundle.select_alu     = ALU_ADD;
      bundle.src1_sel       = 1'b0;
      bundle.src2_sel       = 1'b1;
      bundle.imm            = imm_i;
      bundle.reg_write      = 1'b0;
      bundle.is_branch      = 1'b0;
      bundle.branch_on_zero = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
      bundle.illegal        = 1'b1;
`else
      bundle.illegal        = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/alu_decoder.sv
// Pipelined RV32I decoder: combinational decode feeding a two-entry skid buffer.
// ALU_DEC_ILLEGAL_EN: when defined, unrecognised encodings raise the illegal flag.
module alu_decoder
  import alu_pkg::*;
#(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_DATA-1:0] in_instr,
  input  logic [WIDTH_DATA-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            select_alu,
  output logic                  src1_sel,
  output logic                  src2_sel,
  output logic [WIDTH_DATA-1:0] imm,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_write,
  output logic                  is_branch,
  output logic                  branch_on_zero,
  output logic [WIDTH_DATA-1:0] out_pc,
  output logic                  illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e                state;
  dec_bundle_t           dec_p0;
  dec_bundle_t           main_p1, skid_p1;
  logic [WIDTH_DATA-1:0] main_pc_p1, skid_pc_p1;
  logic                  accept, pop;

  // Stage 0: decode straight off the input port
  alu_dec_comb u_dec (
    .instr  (in_instr),
    .bundle (dec_p0)
  );

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Stage 1: main/skid registers; outputs always come from main
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      main_p1    <= '0;
      skid_p1    <= '0;
      main_pc_p1 <= '0;
      skid_pc_p1 <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            main_p1    <= dec_p0;
            main_pc_p1 <= in_pc;
            out_valid  <= 1'b1;
            state      <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_p1    <= dec_p0;
            main_pc_p1 <= in_pc;
          end else if (accept) begin
            skid_p1    <= dec_p0;
            skid_pc_p1 <= in_pc;
            in_ready   <= 1'b0;
            state      <= S_FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_p1    <= skid_p1;
            main_pc_p1 <= skid_pc_p1;
            in_ready   <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

  assign select_alu     = main_p1.select_alu;
  assign src1_sel       = main_p1.src1_sel;
  assign src2_sel       = main_p1.src2_sel;
  assign imm            = main_p1.imm;
  assign rs1            = main_p1.rs1;
  assign rs2            = main_p1.rs2;
  assign rd             = main_p1.rd;
  assign reg_write      = main_p1.reg_write;
  assign is_branch      = main_p1.is_branch;
  assign branch_on_zero = main_p1.branch_on_zero;
  assign illegal        = main_p1.illegal;
  assign out_pc         = main_pc_p1;

endmodule
